rscpu_core_param: RTL and testbench
===================================

Name: rscpu_core_param

Overview:
Parametrised successor to the fixed 8-bit accumulator datapath: a complete multicycle accumulator CPU core with AC, R, PC, IR, an operand address register and a Z flag. Adds an integrated fetch/decode/execute FSM. Data and address widths are configurable. Main memory is external and reached through a req/ready handshake, so wait-state memories are supported. Sits between the top-level SoC wrapper and the memory/peripheral fabric.

Parameters:
DATA_W, 8, width of AC, R, IR and memory words; must be >= 5.
ADDR_W, 16, width of PC and memory address; must be an integer multiple of DATA_W; ADDR_BYTES = ADDR_W/DATA_W.
RESET_PC, 0, PC value after reset.

Ports:
clk  in  1  core clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
mem_req  out  1  memory transaction request.
mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
mem_addr  out  ADDR_W  transaction address.
mem_wdata  out  DATA_W  write data (= AC).
mem_rdata  in  DATA_W  read data; sampled on the edge where mem_ready = 1.
mem_ready  in  1  transaction completes on a rising edge with mem_req = 1 and mem_ready = 1.
ac_out  out  DATA_W  accumulator.
r_out  out  DATA_W  R register.
z_out  out  1  zero flag.
pc_out  out  ADDR_W  program counter.
halted  out  1  core is in HALT; meaningful only with the optional feature, otherwise tied to 0.

Behaviour:
- Reset (synchronous, active-high): AC = 0, R = 0, Z = 0, IR = 0, TMP = 0, PC = RESET_PC, state = FETCH, halted = 0. mem_req is forced to 0 while reset = 1. A reset during an outstanding transaction abandons it; the core issues no write afterwards.
- Handshake: while mem_req = 1, mem_addr, mem_we and mem_wdata stay stable until the completing edge. mem_ready is ignored when mem_req = 0. There is no timeout.
- Opcode = IR[3:0].
  - 0 NOP.
  - 1 LDAC Γ: AC = M[Γ].
  - 2 STAC Γ: M[Γ] = AC.
  - 3 MVAC: R = AC.
  - 4 MOVR: AC = R.
  - 5 JUMP Γ.
  - 6 JMPZ Γ: jump if Z = 1.
  - 7 JPNZ Γ: jump if Z = 0.
  - 8 ADD: AC = AC + R.
  - 9 SUB: AC = AC - R.
  - A INAC: AC = AC + 1.
  - B CLAC: AC = 0.
  - C AND: AC = AC & R.
  - D OR: AC = AC | R.
  - E XOR: AC = AC ^ R.
  - F NOT: AC = ~AC.
- IR[DATA_W-1:4] is ignored except as defined under Optional Feature.
- Arithmetic: modulo 2^DATA_W, with no carry or overflow flag. PC increments modulo 2^ADDR_W, so FFFF + 1 = 0000.
- Z flag: updated only by opcodes 8 through F, Z = (new AC == 0). All other opcodes leave Z unchanged.
- FSM states:
  - FETCH: read at mem_addr = PC. On completion, IR = mem_rdata, PC = PC + 1, go to DECODE.
  - DECODE (one cycle, no memory request): execute opcodes 0, 3, 4 and 8 through F, then go to FETCH. Opcodes 1, 2 and 5 through 7 go to OPND with byte index k = 0.
  - OPND: read at PC. On completion, TMP[k*DATA_W +: DATA_W] = rdata (least-significant byte first) and PC = PC + 1. When k = ADDR_BYTES-1:
    - LDAC/STAC go to MEMOP.
    - JUMP, taken JMPZ and taken JPNZ set PC = assembled address and go to FETCH.
    - Not-taken branches go to FETCH with PC past the operand.
  - OPND, otherwise (k < ADDR_BYTES-1): k = k + 1 and stay in OPND.
  - MEMOP: mem_addr = TMP. LDAC reads (AC = rdata on completion). STAC writes AC. Then go to FETCH.
- Latency with zero wait states (mem_ready tied to 1) and defaults: NOP/ALU ops/MVAC/MOVR take 2 cycles, jumps take 4, LDAC/STAC take 5. Each wait cycle adds 1.
- If a jump targets its own address, the core loops legally.

Optional Feature:
RSCPU_HALT_EN.
- Defined: a word with IR[4] = 1 and IR[3:0] = 0 is HALT. In DECODE the core enters HALT: halted = 1, mem_req = 0, and all registers are frozen. Only reset leaves HALT.
- Undefined: that word executes as NOP, no HALT state exists, and halted is tied to 0.

Test Plan:
1. Reset then release, with mem_ready = 1 and M[0] = 0x0A (INAC) -> after 2 cycles AC = 0x01, Z = 0, PC = 0x0001.
2. LDAC 0x1234 (bytes 01,34,12) with M[0x1234] = 0xFF, then INAC -> AC = 0x00, Z = 1, PC = 4. LDAC completes in 5 cycles.
3. STAC 0x8000 with AC = 0x5A and mem_ready low for 3 cycles in MEMOP -> mem_req, mem_addr = 0x8000, mem_we = 1 and mem_wdata = 0x5A are held stable for 4 cycles; exactly one write occurs.
4. JMPZ 0x0040 executed with Z = 0 and then with Z = 1 -> PC = 3 when not taken; PC = 0x0040 when taken.
5. AC = 0x80, MVAC, ADD -> AC = 0x00, Z = 1; then SUB with AC = 0, R = 0x80 -> AC = 0x80, Z = 0.
6. Reset asserted mid-OPND during a wait state -> next cycle mem_req = 0 and PC = RESET_PC. With RSCPU_HALT_EN, opcode 0x10 -> halted = 1, PC frozen.

Source files
------------

// File: rtl/rscpu_core_param.sv
// rscpu_core_param: parametrised multicycle accumulator CPU core.
// Registers AC, R, PC, IR, an operand address register (TMP) and a Z flag.
// A fetch/decode/operand/memop FSM drives an external req/ready memory port,
// so wait-state memories work without any timeout.
// Optional feature: define RSCPU_HALT_EN to decode IR[4]=1, IR[3:0]=0 as HALT.
// Without it that word is a NOP and halted is tied low.
module rscpu_core_param #(
  parameter int unsigned           DATA_W   = 8,
  parameter int unsigned           ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ac_out,
  output logic [DATA_W-1:0] r_out,
  output logic              z_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  // Number of memory words that make up one operand address, and the width
  // of the byte index that walks them (at least one bit).
  localparam int unsigned ADDR_BYTES = ADDR_W / DATA_W;
  localparam int unsigned KW         = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(ADDR_BYTES - 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_OPND   = 3'd2;
  localparam logic [2:0] S_MEMOP  = 3'd3;
`ifdef RSCPU_HALT_EN
  localparam logic [2:0] S_HALT   = 3'd4;
`endif

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVAC = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_JUMP = 4'h5;
  localparam logic [3:0] OP_JMPZ = 4'h6;
  localparam logic [3:0] OP_JPNZ = 4'h7;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_INAC = 4'hA;
  localparam logic [3:0] OP_CLAC = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_NOT  = 4'hF;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] ac_q,    ac_d;
  logic [DATA_W-1:0] r_q,     r_d;
  logic              z_q,     z_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [DATA_W-1:0] ir_q,    ir_d;
  logic [ADDR_W-1:0] tmp_q,   tmp_d;
  logic [KW-1:0]     k_q,     k_d;

  logic [3:0]        opcode;
  logic [DATA_W-1:0] alu_res;
  logic [ADDR_W-1:0] tmp_merged;
  logic              req_c;
  logic              we_c;
  logic [ADDR_W-1:0] addr_c;

  assign opcode = ir_q[3:0];

  // Upper IR bits only matter for HALT decode; collect them so the rest
  // of the word is visibly intentionally ignored.
  logic unused_ir_bits;
  assign unused_ir_bits = &{1'b0, ir_q[DATA_W-1:4]};

  // ALU result for opcodes 8..F, all modulo 2^DATA_W.
  always_comb begin
    alu_res = ac_q;
    case (opcode)
      OP_ADD:  alu_res = ac_q + r_q;
      OP_SUB:  alu_res = ac_q - r_q;
      OP_INAC: alu_res = ac_q + DATA_W'(1);
      OP_CLAC: alu_res = '0;
      OP_AND:  alu_res = ac_q & r_q;
      OP_OR:   alu_res = ac_q | r_q;
      OP_XOR:  alu_res = ac_q ^ r_q;
      OP_NOT:  alu_res = ~ac_q;
      default: alu_res = ac_q;
    endcase
  end

  // Operand register with the incoming word dropped into byte slot k
  // (least-significant word first).
  always_comb begin
    tmp_merged = tmp_q;
    for (int b = 0; b < int'(ADDR_BYTES); b++) begin
      if (k_q == KW'(b)) begin
        tmp_merged[b*DATA_W +: DATA_W] = mem_rdata;
      end
    end
  end

  // Next-state and memory-port logic for the fetch/decode/execute FSM.
  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    r_d     = r_q;
    z_d     = z_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    tmp_d   = tmp_q;
    k_d     = k_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = pc_q;

    case (state_q)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_LDAC, OP_STAC, OP_JUMP, OP_JMPZ, OP_JPNZ: begin
            state_d = S_OPND;
            k_d     = '0;
          end
          OP_MVAC: r_d = ac_q;
          OP_MOVR: ac_d = r_q;
          default: begin
            if (opcode[3]) begin
              ac_d = alu_res;
              z_d  = (alu_res == '0);
            end
          end
        endcase
`ifdef RSCPU_HALT_EN
        if ((opcode == OP_NOP) && ir_q[4]) begin
          state_d = S_HALT;
        end
`endif
      end

      S_OPND: begin
        req_c  = 1'b1;
        addr_c = pc_q;
        if (mem_ready) begin
          tmp_d = tmp_merged;
          pc_d  = pc_q + ADDR_W'(1);
          if (k_q == K_LAST) begin
            state_d = S_FETCH;
            case (opcode)
              OP_LDAC, OP_STAC: state_d = S_MEMOP;
              OP_JUMP:          pc_d = tmp_merged;
              OP_JMPZ:          if (z_q)  pc_d = tmp_merged;
              OP_JPNZ:          if (!z_q) pc_d = tmp_merged;
              default:          state_d = S_FETCH;
            endcase
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      S_MEMOP: begin
        req_c  = 1'b1;
        addr_c = tmp_q;
        we_c   = (opcode == OP_STAC);
        if (mem_ready) begin
          if (opcode != OP_STAC) begin
            ac_d = mem_rdata;
          end
          state_d = S_FETCH;
        end
      end

`ifdef RSCPU_HALT_EN
      // Frozen until reset.
      S_HALT: state_d = S_HALT;
`endif

      default: state_d = S_FETCH;
    endcase
  end

  // State and architectural registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ac_q    <= '0;
      r_q     <= '0;
      z_q     <= 1'b0;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      tmp_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      r_q     <= r_d;
      z_q     <= z_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tmp_q   <= tmp_d;
      k_q     <= k_d;
    end
  end

  // Request is masked during reset so an abandoned transaction never
  // completes; address/we/wdata come straight from registered state.
  assign mem_req   = req_c & ~reset;
  assign mem_we    = we_c;
  assign mem_addr  = addr_c;
  assign mem_wdata = ac_q;

  assign ac_out = ac_q;
  assign r_out  = r_q;
  assign z_out  = z_q;
  assign pc_out = pc_q;

`ifdef RSCPU_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_rscpu_core_param.sv
// Self-checking bench for rscpu_core_param (default parameters).
// Directed scenarios followed by random programs compared against an
// instruction-level interpreter of the ISA.
module tb_rscpu_core_param;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [7:0]  ac_out;
  logic [7:0]  r_out;
  logic        z_out;
  logic [15:0] pc_out;
  logic        halted;

  int nchecks = 0;
  int nerrors = 0;
  int wr_count;

  // img is the memory image loaded by the stimulus; mem is the live memory
  // seen by the core, reloaded from img on every reset cycle.
  logic [7:0] img [0:65535];
  logic [7:0] mem [0:65535];
  logic [7:0] mm  [0:65535];

  int   rdy_mode;   // 0: always ready, 1: random, 2: manual
  logic man_rdy;
  logic rnd_bit;

  rscpu_core_param dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .ac_out    (ac_out),
    .r_out     (r_out),
    .z_out     (z_out),
    .pc_out    (pc_out),
    .halted    (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? rnd_bit : man_rdy;

  // Random ready changes right after each edge so it is stable when sampled.
  always @(posedge clk) rnd_bit <= ($urandom_range(0, 2) != 0);

  // Memory side: reload on reset, perform completed writes.
  always @(posedge clk) begin
    if (reset) begin
      mem      <= img;
      wr_count <= 0;
    end else if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 65536; i++) img[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic has_opnd(input logic [3:0] o);
    return (o == 4'h1) || (o == 4'h2) || (o == 4'h5) || (o == 4'h6) || (o == 4'h7);
  endfunction

  // Random straight-line program with forward branches, ending in a
  // jump-to-self; the interpreter result is compared with the core.
  task automatic run_random(input int idx);
    logic [7:0]  iw [24];
    logic [15:0] ia [25];
    logic [15:0] e, t, pc;
    logic [7:0]  ac, r;
    logic [3:0]  op, hi;
    logic        z, done;
    int          wr, lim;

    clear_img();
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      hi = 4'($urandom_range(0, 15));
      if (op == 4'h0) hi[0] = 1'b0;
      iw[i] = {hi, op};
    end
    e = 16'h0000;
    for (int i = 0; i < 24; i++) begin
      ia[i] = e;
      e = e + (has_opnd(iw[i][3:0]) ? 16'd3 : 16'd1);
    end
    ia[24] = e;
    for (int i = 0; i < 24; i++) begin
      op = iw[i][3:0];
      img[ia[i]] = iw[i];
      if (has_opnd(op)) begin
        if (op == 4'h1 || op == 4'h2) t = 16'h8000 + 16'($urandom_range(0, 15));
        else                          t = ia[(i + 2 > 24) ? 24 : i + 2];
        img[ia[i] + 16'd1] = t[7:0];
        img[ia[i] + 16'd2] = t[15:8];
      end
    end
    img[e]         = 8'h05;
    img[e + 16'd1] = e[7:0];
    img[e + 16'd2] = e[15:8];
    for (int j = 0; j < 16; j++) img[16'h8000 + 16'(j)] = 8'($urandom);

    // Instruction-level reference interpreter.
    mm = img;
    pc = 16'h0000; ac = 8'h00; r = 8'h00; z = 1'b0; wr = 0; lim = 0; t = 16'h0000;
    while (pc != e && lim < 200) begin
      lim++;
      op = mm[pc][3:0];
      pc = pc + 16'd1;
      if (has_opnd(op)) begin
        t  = {mm[pc + 16'd1], mm[pc]};
        pc = pc + 16'd2;
      end
      case (op)
        4'h1: ac = mm[t];
        4'h2: begin mm[t] = ac; wr++; end
        4'h3: r = ac;
        4'h4: ac = r;
        4'h5: pc = t;
        4'h6: if (z)  pc = t;
        4'h7: if (!z) pc = t;
        4'h8: ac = ac + r;
        4'h9: ac = ac - r;
        4'hA: ac = ac + 8'd1;
        4'hB: ac = 8'h00;
        4'hC: ac = ac & r;
        4'hD: ac = ac | r;
        4'hE: ac = ac ^ r;
        4'hF: ac = ~ac;
        default: ;
      endcase
      if (op >= 4'h8) z = (ac == 8'h00);
    end

    rdy_mode = 1;
    do_reset();
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(posedge clk); #1;
      if (mem_req && !mem_we && mem_addr == e && mem_ready) done = 1'b1;
    end
    @(posedge clk); #1;
    chk($sformatf("rand%0d_done", idx), 32'(done), 32'd1);
    chk($sformatf("rand%0d_ac", idx), 32'(ac_out), 32'(ac));
    chk($sformatf("rand%0d_r", idx), 32'(r_out), 32'(r));
    chk($sformatf("rand%0d_z", idx), 32'(z_out), 32'(z));
    chk($sformatf("rand%0d_writes", idx), 32'(wr_count), 32'(wr));
    for (int j = 0; j < 16; j++)
      chk($sformatf("rand%0d_mem%0d", idx, j), 32'(mem[16'h8000 + 16'(j)]), 32'(mm[16'h8000 + 16'(j)]));
  endtask

  initial begin
    reset    = 1'b1;
    rdy_mode = 0;
    man_rdy  = 1'b1;

    // Reset state and first INAC.
    clear_img();
    img[0] = 8'h0A;
    cycles(2);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ac", 32'(ac_out), 32'd0);
    chk("rst_r", 32'(r_out), 32'd0);
    chk("rst_z", 32'(z_out), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("fetch_req", 32'({mem_req, mem_we, mem_addr}), 32'h20000);
    cycles(2);
    chk("inac_ac", 32'(ac_out), 32'h01);
    chk("inac_z", 32'(z_out), 32'd0);
    chk("inac_pc", 32'(pc_out), 32'h0001);

    // LDAC 0x1234 then INAC: wraps to zero and sets Z.
    clear_img();
    img[0] = 8'h01; img[1] = 8'h34; img[2] = 8'h12; img[3] = 8'h0A;
    img[16'h1234] = 8'hFF;
    do_reset();
    cycles(4);
    chk("ldac_not_yet", 32'(ac_out), 32'h00);
    cycles(1);
    chk("ldac_ac", 32'(ac_out), 32'hFF);
    chk("ldac_pc", 32'(pc_out), 32'h0003);
    cycles(2);
    chk("wrap_ac", 32'(ac_out), 32'h00);
    chk("wrap_z", 32'(z_out), 32'd1);
    chk("wrap_pc", 32'(pc_out), 32'h0004);

    // STAC 0x8000 with three wait states: port held stable, one write.
    clear_img();
    img[0] = 8'h01; img[1] = 8'h00; img[2] = 8'h01;
    img[3] = 8'h02; img[4] = 8'h00; img[5] = 8'h80;
    img[16'h0100] = 8'h5A;
    rdy_mode = 2;
    man_rdy  = 1'b1;
    do_reset();
    cycles(9);
    man_rdy = 1'b0;
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("stac_hold%0d", w), 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'h03_8000_5A);
      chk($sformatf("stac_nowr%0d", w), 32'(wr_count), 32'd0);
      if (w == 3) man_rdy = 1'b1;
      if (w < 3) cycles(1);
    end
    cycles(1);
    chk("stac_wr_count", 32'(wr_count), 32'd1);
    chk("stac_mem", 32'(mem[16'h8000]), 32'h5A);
    cycles(20);
    chk("stac_single", 32'(wr_count), 32'd1);
    rdy_mode = 0;

    // JMPZ not taken (Z=0), then taken after CLAC.
    clear_img();
    img[0] = 8'h06; img[1] = 8'h40; img[2] = 8'h00;
    do_reset();
    cycles(4);
    chk("jmpz_nt_pc", 32'(pc_out), 32'h0003);
    clear_img();
    img[0] = 8'h0B; img[1] = 8'h06; img[2] = 8'h40; img[3] = 8'h00;
    do_reset();
    cycles(6);
    chk("jmpz_t_z", 32'(z_out), 32'd1);
    chk("jmpz_t_pc", 32'(pc_out), 32'h0040);

    // ADD wraps to zero; SUB 0 - 0x80.
    clear_img();
    img[0] = 8'h01; img[1] = 8'h00; img[2] = 8'h01;
    img[3] = 8'h03; img[4] = 8'h08; img[5] = 8'h09;
    img[16'h0100] = 8'h80;
    do_reset();
    cycles(9);
    chk("add_ac", 32'(ac_out), 32'h00);
    chk("add_z", 32'(z_out), 32'd1);
    chk("add_r", 32'(r_out), 32'h80);
    cycles(2);
    chk("sub_ac", 32'(ac_out), 32'h80);
    chk("sub_z", 32'(z_out), 32'd0);

    // Reset during an OPND wait state abandons the read.
    clear_img();
    img[0] = 8'h05; img[1] = 8'h00; img[2] = 8'h02;
    rdy_mode = 2;
    man_rdy  = 1'b1;
    do_reset();
    cycles(2);
    man_rdy = 1'b0;
    cycles(2);
    chk("opnd_wait_pc", 32'(pc_out), 32'h0001);
    chk("opnd_wait_req", 32'({mem_req, mem_addr}), 32'h10001);
    reset = 1'b1;
    cycles(1);
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_pc", 32'(pc_out), 32'h0000);
    @(negedge clk);
    reset    = 1'b0;
    man_rdy  = 1'b1;
    rdy_mode = 0;

    // Word 0x10: HALT when the feature is built in, NOP otherwise.
    clear_img();
    img[0] = 8'h10; img[1] = 8'h0A;
    do_reset();
`ifdef RSCPU_HALT_EN
    cycles(2);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc_out), 32'h0001);
    cycles(10);
    chk("halt_frozen", 32'({halted, mem_req, pc_out, ac_out}), 32'h2_0001_00);
`else
    cycles(4);
    chk("nop10_ac", 32'(ac_out), 32'h01);
    chk("nop10_pc", 32'(pc_out), 32'h0002);
    chk("nop10_halted", 32'(halted), 32'd0);
`endif

    for (int p = 0; p < 20; p++) run_random(p);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
